// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 2;
  localparam int ARB_MAX_HOLD = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of cand scanning upward from ptr, wrapping at N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         cand,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// Registered round-robin arbiter with a hold limit that forces rotation under contention.
module arbiter_rr
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  output logic         busy
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  arb_state_t     state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  ptr;
  logic [HW-1:0]  hold_cnt;

  logic [N-1:0]   others;
  logic [IW-1:0]  req_idx;
  logic           req_found;
  logic [IW-1:0]  oth_idx;
  logic           oth_found;
  logic           own_req;
  logic           hold_full;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    others        = request;
    others[owner] = 1'b0;
  end

  assign own_req   = request[owner];
  assign hold_full = (hold_cnt == HOLD_MAX);

  rr_pick #(.N(N)) u_pick_req (
    .cand  (request),
    .ptr   (ptr),
    .idx   (req_idx),
    .found (req_found)
  );

  rr_pick #(.N(N)) u_pick_oth (
    .cand  (others),
    .ptr   (ptr),
    .idx   (oth_idx),
    .found (oth_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_found) begin
            state    <= OWNED;
            owner    <= req_idx;
            grant    <= onehot(req_idx);
            busy     <= 1'b1;
            hold_cnt <= HOLD_ONE;
            ptr      <= next_idx(req_idx);
          end
        end
        OWNED: begin
          // Release or exhausted hold with a waiter: hand straight over, no idle gap.
          if ((!own_req || hold_full) && oth_found) begin
            owner    <= oth_idx;
            grant    <= onehot(oth_idx);
            busy     <= 1'b1;
            hold_cnt <= HOLD_ONE;
            ptr      <= next_idx(oth_idx);
          end else if (!own_req) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= next_idx(owner);
          end else if (!hold_full) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: directed vector table, lone-requester sequence, then random traffic vs a reference model.
module tb_arbiter_rr;
  localparam int N        = 2;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic         busy;

  int checks = 0;
  int passes = 0;

  arbiter_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner as an integer (-1 = nobody), consecutive cycles held, next-priority index.
  int           m_owner = -1;
  int           m_held  = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_grant = '0;
  logic [N-1:0] prev_req = '0;

  function automatic int pick(input logic [N-1:0] c, input int from);
    for (int k = 0; k < N; k++)
      if (c[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic void model_edge(input logic r, input logic [N-1:0] req);
    int nxt;
    logic [N-1:0] oth;
    nxt = -1;
    oth = req;
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      nxt = pick(req, m_ptr);
    end else if (!req[m_owner] || m_held >= MAX_HOLD) begin
      oth[m_owner] = 1'b0;
      nxt = pick(oth, m_ptr);
      if (nxt < 0 && !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_held++;
    end
    if (nxt >= 0) begin
      m_owner = nxt;
      m_held  = 1;
      m_ptr   = (nxt + 1) % N;
    end
    m_grant = '0;
    if (m_owner >= 0) m_grant[m_owner] = 1'b1;
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] req);
    prev_req = req;
    rst      = r;
    request  = req;
    @(posedge clk);
    model_edge(r, req);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [N-1:0] exp_g);
    checks++;
    if (grant === exp_g && busy === (exp_g != '0)) passes++;
    else $display("FAIL %s: grant=%b busy=%b, expected grant=%b busy=%b",
                  name, grant, busy, exp_g, (exp_g != '0));
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic [N-1:0] g;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [N-1:0] req,
                              input logic [N-1:0] g, input string name);
    vec_t v;
    v.r = r; v.req = req; v.g = g; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] rq;

    // Reset, single request, release to idle, ptr-driven pick.
    add(1, 2'b00, 2'b00, "reset0");
    add(1, 2'b00, 2'b00, "reset1");
    add(0, 2'b01, 2'b01, "single_grant");
    add(0, 2'b01, 2'b01, "single_hold1");
    add(0, 2'b01, 2'b01, "single_hold2");
    add(0, 2'b00, 2'b00, "release_idle");
    add(0, 2'b11, 2'b10, "ptr1_pick");
    // Contention with owner 1 already granted: rotation every MAX_HOLD cycles.
    for (int i = 0; i < 3; i++) add(0, 2'b11, 2'b10, "cont_own1");
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b01, "cont_own0");
    add(0, 2'b11, 2'b10, "cont_back1");
    // Simultaneous release and new request, both directions.
    add(0, 2'b01, 2'b01, "swap_to0");
    add(0, 2'b10, 2'b10, "swap_to1");
    // Contention straight out of reset: ptr=0 so requester 0 wins first.
    add(1, 2'b11, 2'b00, "reset_cont");
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b01, "idle_cont0");
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b10, "idle_cont1");
    add(0, 2'b11, 2'b01, "idle_cont0b");
    for (int i = 0; i < 3; i++) add(0, 2'b11, 2'b01, "idle_cont0c");
    add(0, 2'b11, 2'b10, "pre_reset1");
    // Reset mid-grant clears grant and ptr.
    add(1, 2'b11, 2'b00, "reset_mid");
    add(0, 2'b11, 2'b01, "after_reset");

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].req);
      check(vecs[i].name, vecs[i].g);
    end

    // Lone requester 1 for 10 cycles, then requester 0 joins against a saturated counter.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 2'b10);
      check("lone_hold", 2'b10);
    end
    cycle(0, 2'b11);
    check("lone_preempt", 2'b01);

    // Random level-held traffic with occasional resets.
    cycle(1, '0);
    check("rand_reset", m_grant);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      r = ($urandom_range(0, 199) == 0);
      cycle(r, rq);
      check("rand_model", m_grant);
      checks++;
      if ($onehot0(grant) && ((grant & ~prev_req) == '0 || r)) passes++;
      else $display("FAIL rand_invariant: grant=%b request_sampled=%b", grant, prev_req);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
# arbiter_rr

Registered round-robin arbiter. It is the responder side of the request/grant handshake used by the arbiter test benches. It takes N request lines and drives a one-hot (or all-zero) grant vector one clock after sampling. A hold limit forces ownership to rotate when other requesters are waiting.

## Interface
- `N`, default 2: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while another requester is pending; legal range ≥ 1.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `request` input, N bits: request line per requester; level-sensitive, held by the requester until it is done.
- `grant` output, N bits: registered grant; one-hot or all zero.
- `busy` output, 1 bit: registered; high whenever `grant` is non-zero.

## Operation
- Internal state:
  - FSM with states IDLE and OWNED.
  - `owner` index, `$clog2(N)` bits.
  - `ptr`, the next-priority index, `$clog2(N)` bits.
  - `hold_cnt`, `$clog2(MAX_HOLD+1)` bits.
- Pick function: the first set bit of a candidate vector, scanning from `ptr` upward with wrap modulo N.
- Reset (`rst`=1 at an edge):
  - `grant`=0, `busy`=0.
  - state IDLE, `ptr`=0, `owner`=0, `hold_cnt`=0.
  - `rst` overrides every other input, including mid-grant.
- IDLE:
  - If `request`≠0, pick over `request`, set `owner`=pick, `grant`=one-hot(pick), `hold_cnt`=1, and go to OWNED.
  - Otherwise stay in IDLE with `grant`=0.
- OWNED, evaluated each edge. Let `others` = `request` with the owner bit cleared.
  - Release case: `request[owner]`=0.
    - If `others`≠0, hand over directly to pick(`others`), with no idle gap.
    - Otherwise set `grant`=0 and go to IDLE.
  - Pre-emption case: `request[owner]`=1, `hold_cnt`=MAX_HOLD and `others`≠0. Hand over to pick(`others`).
  - Otherwise keep `grant` unchanged and set `hold_cnt` = min(`hold_cnt`+1, MAX_HOLD). The counter saturates; a lone requester is never pre-empted.
- On every handover or new grant:
  - `hold_cnt` ← 1.
  - `ptr` ← (new owner + 1) mod N.
- On release to IDLE, `ptr` ← (`owner` + 1) mod N.
- Invariant: `grant` is zero or one-hot, and any set grant bit corresponds to a request that was high at the previous edge.
- If a requester raises `request` while another owns the bus, it waits until release or pre-emption.

## Timing
- Latency from request to grant is 1 cycle:
  - `request` is sampled at edge k.
  - `grant` is valid after edge k.
  - A requester that drives `request` just after edge k−1 sees `grant` after edge k.
- Latency from release to grant clear is 1 cycle. The owner drops `request` before edge k, and `grant` clears after edge k.
- Handover is 1 cycle: the old grant bit falls and the new grant bit rises at the same edge.
- Pre-emption happens at the edge after the owner has held the grant for MAX_HOLD cycles.
- `busy` changes on the same edges as `grant`.
- No combinational path from input to output.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum {IDLE, OWNED}.
  - Default constants `ARB_N`=2 and `ARB_MAX_HOLD`=4.
- Sub-module `rr_pick`: a combinational rotating priority encoder.
  - Parameter: `N`.
  - Inputs: `cand[N-1:0]` and `ptr`.
  - Outputs: `idx` and `found`.
  - It is instantiated twice: over `request` and over `others`.
- Top level `arbiter_rr`: the FSM, the counter, and the output registers.

## Test plan
All scenarios use N=2, MAX_HOLD=4.
1. Reset then single request: `rst`=1 for 2 edges, then 0; drive `request`=01 after an edge → `grant`=01 after the next edge, still 01 two edges later, `busy`=1.
2. Contention from IDLE with `ptr`=0: `request`=11 → `grant`=01 for exactly 4 cycles, then 10 for 4 cycles, then 01 again; never 11 and never 00 between them.
3. Release to IDLE: owner 01 drops → `request`=00 → `grant`=00 after one edge; a following `request`=11 grants 10, since `ptr`=1.
4. Simultaneous release and new request: `request` goes from 01 to 10 at one edge → `grant` goes directly from 01 to 10 at that edge, with no 00 cycle.
5. Lone requester beyond the limit: `request`=10 held for 10 cycles → `grant`=10 throughout. `request[0]` rises at cycle 10 → `grant`=01 on the edge after it is first sampled, since `hold_cnt` is saturated.
6. Reset mid-grant: `grant`=10 and `request`=11 held, `rst`=1 for one edge → `grant`=00 and `busy`=0 after that edge; after reset releases, `grant`=01, since `ptr` was cleared to 0.
